// File: rtl/mux8_scan_seq_pkg.sv
// rtl/mux8_scan_seq_pkg.sv - shared types and widths for the mux8 scan sequencer
package mux8_scan_seq_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/mux8_scan_seq_if.sv
// rtl/mux8_scan_seq_if.sv - upstream word, mux stage and result handshake bundle
interface mux8_scan_seq_if;
  import mux8_scan_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] mux_data;
  logic [SEL_W-1:0]  mux_sel;
  logic              mux_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic              busy;

  // slave is the sequencer's view; master is the surrounding logic
  modport slave (
    input  in_valid, in_data, mux_out, out_ready,
    output in_ready, mux_data, mux_sel, out_valid, out_data, out_err, busy
  );

  modport master (
    output in_valid, in_data, mux_out, out_ready,
    input  in_ready, mux_data, mux_sel, out_valid, out_data, out_err, busy
  );

endinterface

// File: rtl/mux8_settle_timer.sv
// rtl/mux8_settle_timer.sv - loadable down-counter that times the mux settle window
module mux8_settle_timer
  import mux8_scan_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(SETTLE_CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mux8_scan_seq.sv
// rtl/mux8_scan_seq.sv - walks an 8:1 mux select, samples its output and rebuilds the byte
// Optional feature: MUX8_SCAN_SEQ_CHECK_EN adds the readback comparator on out_err.
module mux8_scan_seq
  import mux8_scan_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux8_scan_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_SCAN = SCAN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              load;
  logic              expired;
  logic              scanning;

  assign scanning = (state_q == ST_SCAN);

  mux8_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .en      (scanning),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    sel_d    = sel_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          hold_d  = bus.in_data;
          sel_d   = '0;
          load    = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (expired) begin
          shadow_d[sel_q] = bus.mux_out;
          if (sel_q == SEL_LAST) begin
            state_d = ST_DONE;
          end else begin
            sel_d = sel_q + SEL_W'(1);
            load  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          sel_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      shadow_q <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      sel_q    <= sel_d;
    end
  end

`ifdef MUX8_SCAN_SEQ_CHECK_EN
  logic err_q, err_d;

  // bit7 is still in flight on the DONE-entry edge, so splice in the live sample
  always_comb begin
    err_d = err_q;
    if (scanning && expired && (sel_q == SEL_LAST)) begin
      err_d = ({bus.mux_out, shadow_q[DATA_W-2:0]} != hold_q);
    end else if ((state_q == ST_DONE) && bus.out_ready) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mux_data  = hold_q;
  assign bus.mux_sel   = sel_q;
  assign bus.out_data  = shadow_q;

endmodule

// File: tb/tb_mux8_scan_seq.sv
// tb/tb_mux8_scan_seq.sv - directed bench with a timing-rule model for two settle configurations
module tb_mux8_scan_seq;
  import mux8_scan_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, stuck0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mux8_scan_seq_if if0 ();
  mux8_scan_seq_if if1 ();

  // behavioural 8:1 mux stage; instance 0 can force its output low
  assign if0.mux_out = stuck0 ? 1'b0 : if0.mux_data[if0.mux_sel];
  assign if1.mux_out = if1.mux_data[if1.mux_sel];

  mux8_scan_seq #(.SETTLE_CYCLES(1)) u0 (.clk(clk), .rst_n(rst0_n), .bus(if0.slave));
  mux8_scan_seq #(.SETTLE_CYCLES(0)) u1 (.clk(clk), .rst_n(rst1_n), .bus(if1.slave));

`ifdef MUX8_SCAN_SEQ_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: state is "cycles since acceptance", outputs follow from the timing rules
  int       settle [2] = '{1, 0};
  bit       started[2] = '{0, 0};
  bit       m_act  [2] = '{0, 0};
  bit       m_done [2] = '{0, 0};
  int       m_j    [2] = '{0, 0};
  logic [7:0] m_last[2] = '{8'h00, 8'h00};
  logic [7:0] m_word[2] = '{8'h00, 8'h00};
  logic [7:0] m_res [2] = '{8'h00, 8'h00};

  always @(negedge clk) begin
    logic       a_ir[2], a_ov[2], a_bz[2], a_er[2], a_rst[2], a_iv[2], a_or[2];
    logic [2:0] a_sel[2];
    logic [7:0] a_md[2], a_od[2], a_id[2];
    int         sel_e;
    bit         err_e;
    a_ir  = '{if0.in_ready,  if1.in_ready};
    a_ov  = '{if0.out_valid, if1.out_valid};
    a_bz  = '{if0.busy,      if1.busy};
    a_er  = '{if0.out_err,   if1.out_err};
    a_sel = '{if0.mux_sel,   if1.mux_sel};
    a_md  = '{if0.mux_data,  if1.mux_data};
    a_od  = '{if0.out_data,  if1.out_data};
    a_rst = '{rst0_n,        rst1_n};
    a_iv  = '{if0.in_valid,  if1.in_valid};
    a_or  = '{if0.out_ready, if1.out_ready};
    a_id  = '{if0.in_data,   if1.in_data};
    for (int i = 0; i < 2; i++) begin
      if (started[i]) begin
        sel_e = !m_act[i] ? 0 : (m_done[i] ? 7 : m_j[i] / (settle[i] + 1));
        err_e = CHECK_EN && (m_res[i] != m_word[i]);
        check($sformatf("u%0d.in_ready", i),  32'(a_ir[i]),  32'(!m_act[i]));
        check($sformatf("u%0d.busy", i),      32'(a_bz[i]),  32'(m_act[i]));
        check($sformatf("u%0d.out_valid", i), 32'(a_ov[i]),  32'(m_done[i]));
        check($sformatf("u%0d.mux_sel", i),   32'(a_sel[i]), sel_e);
        check($sformatf("u%0d.mux_data", i),  32'(a_md[i]),  32'(m_last[i]));
        check($sformatf("u%0d.out_err", i),   32'(a_er[i]),  32'(m_done[i] && err_e));
        if (m_done[i]) check($sformatf("u%0d.out_data", i), 32'(a_od[i]), 32'(m_res[i]));
      end
      // predict the coming edge from the inputs now held stable
      if (!a_rst[i]) begin
        started[i] = 1'b1;
        m_act[i]   = 1'b0;
        m_done[i]  = 1'b0;
        m_last[i]  = 8'h00;
      end else if (!m_act[i]) begin
        if (a_iv[i]) begin
          m_act[i]  = 1'b1;
          m_j[i]    = 0;
          m_word[i] = a_id[i];
          m_last[i] = a_id[i];
          m_res[i]  = (i == 0 && stuck0) ? 8'h00 : a_id[i];
        end
      end else if (!m_done[i]) begin
        m_j[i]++;
        if (m_j[i] == 8 * (settle[i] + 1)) m_done[i] = 1'b1;
      end else if (a_or[i]) begin
        m_act[i]  = 1'b0;
        m_done[i] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept one word on instance 0, return cycles until out_valid
  task automatic run0(input logic [7:0] w, output int lat, output logic [2:0] sel5);
    if0.in_valid = 1'b1;
    if0.in_data  = w;
    step();
    if0.in_valid = 1'b0;
    lat  = 0;
    sel5 = 3'h0;
    while (!if0.out_valid && lat < 60) begin
      step();
      lat++;
      if (lat == 5) sel5 = if0.mux_sel;
    end
  endtask

  initial begin
    int         lat, c, first_c, second_c;
    logic [2:0] s5, s3;
    logic [7:0] first_d, second_d;
    rst0_n = 1'b0; rst1_n = 1'b0; stuck0 = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = 8'h00; if0.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = 8'h00; if1.out_ready = 1'b0;
    step();
    check("rst.in_ready",  32'(if0.in_ready),  32'd1);
    check("rst.out_valid", 32'(if0.out_valid), 32'd0);
    check("rst.mux_data",  32'(if0.mux_data),  32'h00);
    check("rst.out_data",  32'(if0.out_data),  32'h00);
    rst0_n = 1'b1; rst1_n = 1'b1;
    step();

    // loopback
    if0.out_ready = 1'b1;
    run0(8'hA5, lat, s5);
    check("loop.latency",  32'(lat), 32'd16);
    check("loop.sel_at5",  32'(s5), 32'd2);
    check("loop.out_data", 32'(if0.out_data), 32'hA5);
    check("loop.out_err",  32'(if0.out_err), 32'd0);
    step();
    check("loop.in_ready_after", 32'(if0.in_ready), 32'd1);

    // stuck-at-0 mux output
    stuck0 = 1'b1;
    run0(8'h3C, lat, s5);
    check("stuck.out_data", 32'(if0.out_data), 32'h00);
    check("stuck.out_err",  32'(if0.out_err), 32'(CHECK_EN));
    step();
    stuck0 = 1'b0;

    // backpressure
    if0.out_ready = 1'b0;
    run0(8'h5A, lat, s5);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp.out_valid", 32'(if0.out_valid), 32'd1);
      check("bp.out_data",  32'(if0.out_data), 32'h5A);
      check("bp.mux_sel",   32'(if0.mux_sel), 32'd7);
      check("bp.in_ready",  32'(if0.in_ready), 32'd0);
    end
    if0.out_ready = 1'b1;
    step();
    check("bp.in_ready_after", 32'(if0.in_ready), 32'd1);

    // reset at the bit-3 sample edge (E0+8)
    if0.in_valid = 1'b1;
    if0.in_data  = 8'hC3;
    step();
    if0.in_valid = 1'b0;
    repeat (7) step();
    rst0_n = 1'b0;
    step();
    rst0_n = 1'b1;
    check("rst_mid.in_ready",  32'(if0.in_ready), 32'd1);
    check("rst_mid.out_valid", 32'(if0.out_valid), 32'd0);
    check("rst_mid.mux_sel",   32'(if0.mux_sel), 32'd0);
    check("rst_mid.mux_data",  32'(if0.mux_data), 32'h00);
    run0(8'hFF, lat, s5);
    check("rst_mid.latency",  32'(lat), 32'd16);
    check("rst_mid.out_data", 32'(if0.out_data), 32'hFF);
    step();

    // zero settle, back-to-back on instance 1
    if1.out_ready = 1'b1;
    if1.in_valid  = 1'b1;
    if1.in_data   = 8'h01;
    step();
    if1.in_data = 8'h80;
    c = 0; first_c = -1; second_c = -1; s3 = 3'h0;
    first_d = 8'h00; second_d = 8'h00;
    while (c < 40 && second_c < 0) begin
      step();
      c++;
      if (c == 3) s3 = if1.mux_sel;
      if (c == 10) if1.in_valid = 1'b0;
      if (if1.out_valid) begin
        if (first_c < 0) begin first_c = c; first_d = if1.out_data; end
        else begin second_c = c; second_d = if1.out_data; end
      end
    end
    check("b2b.sel_at3",   32'(s3), 32'd3);
    check("b2b.first_lat", 32'(first_c), 32'd8);
    check("b2b.first",     32'(first_d), 32'h01);
    check("b2b.gap",       32'(second_c - first_c), 32'd10);
    check("b2b.second",    32'(second_d), 32'h80);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux8_scan_seq.md
# mux8_scan_seq

Sequencer that sits directly upstream of the 8:1 combinational multiplexer stage and also takes that stage's single output bit back. Each accepted 8-bit word is presented on the mux data inputs. The block then walks the 3-bit select through positions 0..7, samples the mux output after a programmable settle time, and reassembles a byte. The result goes out on a valid/ready handshake, so the mux stage can be exercised and checked in-system.

## Interface
- `SETTLE_CYCLES`, default 1: idle cycles between a select change and the sample; legal range 0..15.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `in_valid` input, 1 bit: upstream word valid.
- `in_ready` output, 1 bit: block can accept a word.
- `in_data` input, 8 bits: word to scan.
- `mux_data` output, 8 bits: mux data inputs. Bit0 drives `pa` and bit7 drives `ph`.
- `mux_sel` output, 3 bits: mux select. Bit0 drives `pi`, bit1 drives `pj`, bit2 drives `pk`. Value n selects `mux_data[n]`.
- `mux_out` input, 1 bit: mux output `pl`.
- `out_valid` output, 1 bit: reassembled byte available.
- `out_ready` input, 1 bit: downstream accepts the byte.
- `out_data` output, 8 bits: reassembled byte. Bit n is the `mux_out` value sampled while `mux_sel` equalled n.
- `out_err` output, 1 bit: mismatch flag. See Configuration.
- `busy` output, 1 bit: high in SCAN and DONE.

## Operation
FSM has three states: IDLE, SCAN, DONE.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: `hold` <= `in_data`, `sel` <= 0, `cnt` <= `SETTLE_CYCLES`, go to SCAN.
- **SCAN**
  - If `cnt`!=0: `cnt` decrements.
  - If `cnt`==0: `shadow[sel]` <= `mux_out`.
    - If `sel`==7: go to DONE.
    - Otherwise: `sel` increments and `cnt` <= `SETTLE_CYCLES`.
- **DONE**
  - `out_valid`=1.
  - On `out_ready`: go to IDLE and `sel` <= 0.
- **Output sources**
  - `mux_data` = `hold`. It is constant for the whole transaction and keeps the last word while in IDLE.
  - `mux_sel` = `sel`. It stays at 7 during DONE.
  - `out_data` = `shadow`. It only updates in SCAN, so it is stable while `out_valid`=1.
- **Handshake rules**
  - `in_ready` is high only in IDLE, so a word is never accepted during SCAN or DONE.
  - A byte and a new word cannot complete in the same cycle. `in_ready` rises the cycle after the `out_valid`&`out_ready` edge.
  - `out_valid` does not depend combinationally on `out_ready`.
- **Reset values**
  - `in_ready`=1 (state IDLE).
  - `out_valid`=0, `busy`=0.
  - `mux_sel`=0, `mux_data`=0, `out_data`=0, `out_err`=0.
- **Reset mid-operation**
  - `rst_n` low at any edge returns every register to its reset value at that edge.
  - Any in-flight word or pending byte is dropped.

## Timing
- Let E0 be the accepting edge. Bit n is sampled at edge E0+(n+1)·(SETTLE_CYCLES+1).
- `out_valid` is high in the cycle after edge E0+8·(SETTLE_CYCLES+1). Examples: 16 cycles for `SETTLE_CYCLES`=1, 8 cycles for `SETTLE_CYCLES`=0.
- Each `mux_sel` value is held for SETTLE_CYCLES+1 cycles.
- Sustained throughput with `out_ready` tied high is one word per 8·(SETTLE_CYCLES+1)+2 cycles.

## Configuration
- `MUX8_SCAN_SEQ_CHECK_EN` defined:
  - On entry to DONE, `out_err` <= (`shadow` with bit7 replaced by the current sample) != `hold`.
  - `out_err` is valid with `out_valid` and clears on the transfer.
- Not defined:
  - The `out_err` port still exists and is tied to 0.
  - No comparator logic is built.

## Structure
- Package `mux8_scan_seq_pkg` holds:
  - the state enum `scan_state_t` (IDLE, SCAN, DONE);
  - the constants `DATA_W`=8, `SEL_W`=3, `CNT_W`=4.
- One sub-module, `mux8_settle_timer`:
  - loadable down-counter;
  - input `load`, output `expired` when the count is 0;
  - owns `cnt`.
- The FSM, `hold`, `shadow` and `sel` stay in the top module.

## Test plan
- **Loopback:** behavioural 8:1 mux model, `SETTLE_CYCLES`=1, word 8'hA5 → `mux_sel` steps 0..7 with each value held 2 cycles; `out_valid` 16 cycles after acceptance with `out_data`=8'hA5 and `out_err`=0.
- **Stuck-at fault:** `pl` forced to 0, word 8'h3C → `out_data`=8'h00; `out_err`=1 with the macro, 0 without.
- **Backpressure:** `out_ready` low for 5 cycles after `out_valid` → `out_valid`, `out_data` and `mux_sel`=7 stay stable; `in_ready`=0 throughout; `in_ready`=1 the cycle after the transfer.
- **Reset mid-transaction:** `rst_n` low at the bit-3 sample edge → next cycle `in_ready`=1, `out_valid`=0, `mux_sel`=0, `mux_data`=0; a following word 8'hFF completes correctly.
- **Zero settle, back-to-back:** `SETTLE_CYCLES`=0, words 8'h01 then 8'h80 with `in_valid` and `out_ready` held high → `mux_sel` changes every cycle; outputs are 8'h01 then 8'h80, 10 cycles apart.
